// File: rtl/hazard_stall_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_if
// Groups the pipeline-side signals of the hazard/stall controller.
//   master : pipeline/datapath side. It drives register ids, decoded control
//            and dmem_ready, and it receives stall/flush/forward/dmem_req.
//   slave  : the hazard_stall_controller itself.
// Signal names follow the datapath's own naming (Rs1D, RdE, ...), so that the
// wiring in the core top stays one-to-one with the datapath.
// ---------------------------------------------------------------------------
interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  // decode / execute / memory / writeback register ids
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  // decoded control carried down the pipe
  logic             ResultSrcE0;
  logic             RegWriteM, RegWriteW;
  logic             PCSrcE;
  logic             MemAccessM;
  // data memory handshake
  logic             dmem_ready;
  logic             dmem_req;
  // pipeline control
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  // status
  logic             bus_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready,
    input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, bus_err, stall_cycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready,
    output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, bus_err, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// This is the pipeline sequencer for the 5-stage RV32 core. It generates:
//   - the EX operand forwarding selects (00 RF, 01 WB, 10 MEM),
//   - the stage stall and flush enables for load-use, taken branch and dmem
//     wait states,
//   - the data-memory request handshake, with a wait-state timeout that
//     raises a sticky bus error,
//   - a saturating counter of stalled cycles.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous reset, active-high
//   hz   : hazard_stall_controller_if.slave. It carries the register ids and
//          decoded control in, and the stall/flush/forward/dmem_req,
//          bus_err and stall_cycles out.
// Parameters:
//   TIMEOUT : maximum number of cycles an access may wait for dmem_ready
//             (must be >= 2)
//   CNT_W   : width of stall_cycles. It must match the interface's CNT_W.
// ---------------------------------------------------------------------------

// Forwarding select for one EX source operand. The MEM stage beats the WB
// stage because MEM holds the younger write to the same register.
module hazard_fwd_sel (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_wr_m,
  input  logic       i_wr_w,
  output logic [1:0] o_sel
);
  always_comb begin
    o_sel = 2'b00;
    if (i_wr_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs))
      o_sel = 2'b10;
    else if (i_wr_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs))
      o_sel = 2'b01;
  end
endmodule

module hazard_stall_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  hazard_stall_controller_if.slave    hz
);

  localparam int NUM_OPS = 2;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Forwarding: one selector per EX source operand
  // ---------------------------------------------------------------------
  logic [NUM_OPS-1:0][4:0] w_rs_e;
  logic [NUM_OPS-1:0][1:0] w_fwd;

  assign w_rs_e[0] = hz.Rs1E;
  assign w_rs_e[1] = hz.Rs2E;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_sel u_fwd (
      .i_rs   (w_rs_e[g]),
      .i_rd_m (hz.RdM),
      .i_rd_w (hz.RdW),
      .i_wr_m (hz.RegWriteM),
      .i_wr_w (hz.RegWriteW),
      .o_sel  (w_fwd[g])
    );
  end

  assign hz.ForwardAE = w_fwd[0];
  assign hz.ForwardBE = w_fwd[1];

  // ---------------------------------------------------------------------
  // Load-use hazard: the load in EX has not fetched its data in time for
  // the dependent instruction in DE.
  // ---------------------------------------------------------------------
  logic w_lw_stall;
  assign w_lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // ---------------------------------------------------------------------
  // Data-memory access FSM
  // ---------------------------------------------------------------------
  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic              w_dmem_req;
  logic              w_mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_bus_err_nxt = r_bus_err;
    w_dmem_req    = 1'b0;
    w_mem_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dmem_req  = hz.MemAccessM;
        w_mem_stall = hz.MemAccessM && !hz.dmem_ready;
        // A zero-wait access completes here without leaving IDLE. The
        // first wait cycle is the IDLE cycle itself, so the counter
        // enters BUSY already at 1.
        if (hz.MemAccessM && !hz.dmem_ready) begin
          w_state_nxt = S_BUSY;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      S_BUSY: begin
        w_dmem_req  = hz.MemAccessM;
        w_mem_stall = hz.MemAccessM && !hz.dmem_ready;
        if (hz.dmem_ready) begin
          w_state_nxt = S_IDLE;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without ready, so the access is abandoned.
          w_state_nxt   = S_ERR;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_ERR: begin
        // ERR is terminal: the pipeline stays frozen until reset, so the
        // fault is never silently skipped.
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  assign hz.dmem_req = w_dmem_req;
  assign hz.bus_err  = r_bus_err;

  // ---------------------------------------------------------------------
  // Stall / flush priority: memStall > PCSrcE > lwStall.
  // During a memory stall EX is frozen. Any pending redirect or load-use
  // is re-evaluated once the access releases.
  // ---------------------------------------------------------------------
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_w;

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      // WB gets a bubble so that the stalled MEM result is not written twice.
      w_flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign hz.StallF = w_stall_f;
  assign hz.StallD = w_stall_d;
  assign hz.StallE = w_stall_e;
  assign hz.StallM = w_stall_m;
  assign hz.FlushD = w_flush_d;
  assign hz.FlushE = w_flush_e;
  assign hz.FlushW = w_flush_w;

  // ---------------------------------------------------------------------
  // Stall performance counter. It saturates instead of wrapping, so that a
  // long ERR hang reads as "a lot" rather than as a small number.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cycles <= '0;
    else if ((w_mem_stall || w_stall_f) && (r_stall_cycles != {CNT_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) hz();

  hazard_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  //   m_waited : number of cycles the current access has gone without ready
  //   m_err    : the access timed out
  //   m_stalls : stalled cycles seen so far
  bit m_err;
  int m_waited;
  int m_stalls;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_req();
    return hz.MemAccessM && !m_err;
  endfunction

  function automatic bit ref_memstall();
    return (ref_req() && !hz.dmem_ready) || m_err;
  endfunction

  function automatic bit ref_lw();
    return hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  endfunction

  // Expected stage control as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ref_ctl();
    if (ref_memstall()) return 7'b1111_001;
    if (hz.PCSrcE)      return 7'b0000_110;
    if (ref_lw())       return 7'b1100_010;
    return 7'b0;
  endfunction

  task automatic model_reset();
    m_err    = 1'b0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  task automatic check_all();
    logic [6:0] c;
    c = ref_ctl();
    chk("ForwardAE", 32'(hz.ForwardAE), 32'(ref_fwd(hz.Rs1E)));
    chk("ForwardBE", 32'(hz.ForwardBE), 32'(ref_fwd(hz.Rs2E)));
    chk("dmem_req",  32'(hz.dmem_req),  32'(ref_req()));
    chk("ctl", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                    hz.FlushD, hz.FlushE, hz.FlushW}), 32'(c));
    chk("bus_err", 32'(hz.bus_err), 32'(m_err));
    chk("stall_cycles", 32'(hz.stall_cycles), 32'(m_stalls));
  endtask

  task automatic model_clock();
    bit stalled;
    if (rst) return;
    stalled = ref_memstall() || ref_ctl()[6];
    if (stalled && m_stalls < SAT) m_stalls++;
    if (ref_req() && !hz.dmem_ready) begin
      m_waited++;
      if (m_waited >= TIMEOUT) m_err = 1'b1;
    end else if (ref_req() && hz.dmem_ready) begin
      m_waited = 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.ResultSrcE0 = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.PCSrcE = 0; hz.MemAccessM = 0; hz.dmem_ready = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    model_reset();
    at_neg();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    at_neg();
    chk("rst_bus_err", 32'(hz.bus_err), 32'd0);
    chk("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
    tick();
    rst = 1'b0;

    // Forwarding: MEM beats WB, and x0 is never forwarded
    hz.RegWriteM = 1; hz.RdM = 5; hz.RegWriteW = 1; hz.RdW = 5; hz.Rs1E = 5;
    at_neg();
    chk("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
    tick();
    hz.RdM = 0;
    at_neg();
    chk("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
    tick();
    hz.Rs2E = 0; hz.RdW = 0;
    at_neg();
    chk("fwdB_rf", 32'(hz.ForwardBE), 32'd0);
    tick();
    clear_in();

    // Load-use hazard, then a redirect overriding it
    hz.ResultSrcE0 = 1; hz.RdE = 3; hz.Rs2D = 3;
    at_neg();
    chk("lw_stallF", 32'(hz.StallF), 32'd1);
    chk("lw_flushE", 32'(hz.FlushE), 32'd1);
    tick();
    hz.PCSrcE = 1;
    at_neg();
    chk("br_flushD", 32'(hz.FlushD), 32'd1);
    chk("br_stallD", 32'(hz.StallD), 32'd0);
    tick();

    // Three wait states, then completion
    do_reset();
    hz.MemAccessM = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("ws_req", 32'(hz.dmem_req), 32'd1);
      chk("ws_stallM", 32'(hz.StallM), 32'd1);
      chk("ws_flushW", 32'(hz.FlushW), 32'd1);
      tick();
    end
    hz.dmem_ready = 1;
    at_neg();
    chk("ws_done_req", 32'(hz.dmem_req), 32'd1);
    chk("ws_done_stallF", 32'(hz.StallF), 32'd0);
    tick();
    hz.MemAccessM = 0; hz.dmem_ready = 0;
    at_neg();
    chk("ws_count", 32'(hz.stall_cycles), 32'd3);
    tick();

    // Reset asserted mid-BUSY
    hz.MemAccessM = 1;
    at_neg(); tick();
    at_neg(); tick();
    rst = 1'b1;
    model_reset();
    at_neg();
    chk("rstb_req", 32'(hz.dmem_req), 32'd1);
    chk("rstb_cnt", 32'(hz.stall_cycles), 32'd0);
    hz.MemAccessM = 0;
    #1;
    chk("rstb_req0", 32'(hz.dmem_req), 32'd0);
    tick();
    rst = 1'b0;

    // Timeout into ERR, then hold there long enough to saturate the counter
    do_reset();
    hz.MemAccessM = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      at_neg();
      chk("to_req", 32'(hz.dmem_req), 32'd1);
      tick();
    end
    at_neg();
    chk("to_bus_err", 32'(hz.bus_err), 32'd1);
    chk("to_req0", 32'(hz.dmem_req), 32'd0);
    chk("to_stallE", 32'(hz.StallE), 32'd1);
    tick();
    hz.dmem_ready = 1; hz.PCSrcE = 1;
    for (int i = 0; i < SAT; i++) begin
      at_neg();
      tick();
    end
    at_neg();
    chk("sat_count", 32'(hz.stall_cycles), 32'(SAT));
    chk("err_held", 32'(hz.StallF), 32'd1);
    tick();

    // Wait states while a branch is pending in EX
    do_reset();
    hz.MemAccessM = 1; hz.PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("brw_flushD", 32'(hz.FlushD), 32'd0);
      chk("brw_flushE", 32'(hz.FlushE), 32'd0);
      tick();
    end
    hz.dmem_ready = 1;
    at_neg();
    chk("brw_rel_flushD", 32'(hz.FlushD), 32'd1);
    chk("brw_rel_flushE", 32'(hz.FlushE), 32'd1);
    tick();
    hz.MemAccessM = 0;
    at_neg();
    chk("brw_after_flushD", 32'(hz.FlushD), 32'd1);
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
        hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
        hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
        hz.RdW  = 5'($urandom_range(0, 3));
        hz.ResultSrcE0 = 1'($urandom); hz.RegWriteM = 1'($urandom);
        hz.RegWriteW   = 1'($urandom); hz.PCSrcE    = 1'($urandom_range(0, 3) == 0);
        hz.dmem_ready  = 1'($urandom_range(0, 9) < 4);
        // An access that is waiting must keep MemAccessM high.
        if (m_waited > 0 && !m_err) hz.MemAccessM = 1'b1;
        else                        hz.MemAccessM = 1'($urandom);
        at_neg();
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
